pipelined_cla_adder: RTL and testbench

//  Parametrised, pipelined block carry-lookahead adder/subtractor for the Booth multiplier datapath and its successors.

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_block.sv | 54 +++++
 rtl/fulladder.sv | 13 +
 rtl/pipelined_cla_adder.sv | 152 +++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int stages(int n, int blk);
    return n / blk;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational W-bit carry-lookahead group: per-bit carries come from the expanded
// generate/propagate terms, so no carry ripples through the fulladder cells.
module cla_block #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         gen,
  output logic         prop
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic [W-1:0] unused_co;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    logic pp;
    c    = '0;
    c[0] = cin;
    gen  = 1'b0;
    for (int i = 0; i < W; i++) begin
      pp     = p[i];
      c[i+1] = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
      gen    = g[i] | (p[i] & gen);
    end
  end

  assign prop = &p;
  assign cout = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladder u_fa (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .c_i  (c[i]),
      .s_o  (sum[i]),
      .co_o (unused_co[i])
    );
  end

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell used for the per-bit sums of each lookahead group.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined block-CLA adder/subtractor, one BLOCK-bit group per stage, valid/ready streaming.
// Define STATUS_FLAGS_EN to generate the signed-overflow and zero flags.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned STAGES = unsigned'(stages(int'(N), int'(BLOCK)));

  if (N % BLOCK != 0) begin : g_param_err
    $error("pipelined_cla_adder: N must be a multiple of BLOCK");
  end

  logic         adv;
  logic         sub;
  logic [N-1:0] b_eff;
  logic         cin_eff;

  logic [STAGES-1:0]        valid_q, valid_d;
  logic [STAGES-1:0]        carry_q, carry_d;
  logic [STAGES-1:0][N-1:0] a_q, a_d;
  logic [STAGES-1:0][N-1:0] b_q, b_d;
  logic [STAGES-1:0][N-1:0] sum_q, sum_d;

  assign sub     = (op_e'(op) == OP_SUB);
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv      = !valid_q[STAGES-1] | out_ready;
  assign in_ready = adv;

`ifdef STATUS_FLAGS_EN
  logic [STAGES-1:0] sa_q, sa_d;
  logic [STAGES-1:0] sb_q, sb_d;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0]     src_a, src_b, src_sum;
    logic             src_c, src_v;
    logic [BLOCK-1:0] blk_sum;
    logic             blk_cout, blk_gen, blk_prop;
    logic [N-1:0]     nxt_sum;
    logic             unused_gp;

    if (k == 0) begin : g_first
      assign src_a   = a;
      assign src_b   = b_eff;
      assign src_sum = '0;
      assign src_c   = cin_eff;
      assign src_v   = in_valid;
`ifdef STATUS_FLAGS_EN
      assign sa_d[k] = a[N-1];
      assign sb_d[k] = b_eff[N-1];
`endif
    end else begin : g_next
      assign src_a   = a_q[k-1];
      assign src_b   = b_q[k-1];
      assign src_sum = sum_q[k-1];
      assign src_c   = carry_q[k-1];
      assign src_v   = valid_q[k-1];
`ifdef STATUS_FLAGS_EN
      assign sa_d[k] = sa_q[k-1];
      assign sb_d[k] = sb_q[k-1];
`endif
    end

    cla_block #(
      .W (BLOCK)
    ) u_blk (
      .a    (src_a[k*BLOCK +: BLOCK]),
      .b    (src_b[k*BLOCK +: BLOCK]),
      .cin  (src_c),
      .sum  (blk_sum),
      .cout (blk_cout),
      .gen  (blk_gen),
      .prop (blk_prop)
    );

    // Group gen/prop are for a future multi-level lookahead; the stage carry uses cout.
    assign unused_gp = blk_gen ^ blk_prop;

    always_comb begin
      nxt_sum                    = src_sum;
      nxt_sum[k*BLOCK +: BLOCK]  = blk_sum;
    end

    assign a_d[k]     = src_a;
    assign b_d[k]     = src_b;
    assign sum_d[k]   = nxt_sum;
    assign carry_d[k] = blk_cout;
    assign valid_d[k] = src_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
    end
  end

  // Datapath is not reset; everything visible is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // The last stage's operand copies feed nothing and are trimmed by synthesis.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign out_valid = valid_q[STAGES-1];
  assign result    = out_valid ? {carry_q[STAGES-1], sum_q[STAGES-1]} : '0;

`ifdef STATUS_FLAGS_EN
  always_ff @(posedge clk) begin
    if (adv) begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  assign ovf  = out_valid & (sa_q[STAGES-1] ~^ sb_q[STAGES-1])
                          & (sum_q[STAGES-1][N-1] ^ sa_q[STAGES-1]);
  assign zero = out_valid & ~|sum_q[STAGES-1];
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three widths of group (BLOCK=1, 4, 16) against a queue model.
module tb_pipelined_cla_adder;

`ifdef STATUS_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cin, op;
  logic [15:0] a, b;
  logic [2:0]  in_rdy, ov, ovf, zero;
  logic [16:0] res [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  logic [18:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder #(.N(16), .BLOCK(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
    .ovf(ovf[0]), .zero(zero[0])
  );
  pipelined_cla_adder #(.N(16), .BLOCK(4)) u_dut_b4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
    .ovf(ovf[1]), .zero(zero[1])
  );
  pipelined_cla_adder #(.N(16), .BLOCK(16)) u_dut_b16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
    .ovf(ovf[2]), .zero(zero[2])
  );

  // Returns {ovf, zero, carry, sum} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    int          sx, sy, sr;
    int unsigned ur;
    logic [15:0] s;
    logic        co, v, z;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      s  = x - y;
      co = (x >= y);
      sr = sx - sy;
    end else begin
      ur = 32'(x) + 32'(y) + 32'(ci);
      s  = ur[15:0];
      co = ur[16];
      sr = sx + sy + int'(ci);
    end
    v = FLAGS && (sr > 32767 || sr < -32768);
    z = FLAGS && (s == 16'h0000);
    return {v, z, co, s};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [18:0] qfront(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int d, input logic [18:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Compare process: every cycle, every DUT, against its own issue-order queue.
  always @(negedge clk) begin
    if (armed) begin
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        q2.delete();
      end else begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("in_ready_dut%0d", d), 32'(in_rdy[d]), 32'(!ov[d] || out_ready));
          if (ov[d]) begin
            if (qsize(d) == 0) begin
              check($sformatf("stale_beat_dut%0d", d), 32'(ov[d]), 32'd0);
            end else begin
              check($sformatf("result_dut%0d", d), 32'({ovf[d], zero[d], res[d]}),
                    32'(qfront(d)));
              if (out_ready) qpop(d);
            end
          end else begin
            check($sformatf("idle_outputs_dut%0d", d), 32'({ovf[d], zero[d], res[d]}), 32'd0);
          end
          if (in_valid && in_rdy[d]) qpush(d, model(a, b, cin, op));
        end
      end
    end
  end

  task automatic run_one(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb, input logic [16:0] er,
                         input logic eo, input logic ez);
    logic [18:0] m;
    int          t0;
    bit          ok;
    m = model(x, y, ci, sb);
    check({name, "_model_res"}, 32'(m[16:0]), 32'(er));
    check({name, "_model_flags"}, 32'(m[18:17]), FLAGS ? 32'({eo, ez}) : 32'd0);
    @(posedge clk); #1;
    a = x; b = y; cin = ci; op = sb; in_valid = 1'b1; out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_rdy[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_accepted"}, 32'(ok), 32'd1);
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_out_seen"}, 32'(ok), 32'd1);
    check({name, "_latency"}, 32'(cyc - t0), 32'd4);
    check({name, "_result"}, 32'(res[1]), 32'(er));
    check({name, "_flags"}, 32'({ovf[1], zero[1]}), FLAGS ? 32'({eo, ez}) : 32'd0);
  endtask

  initial begin
    int          bi, ng;
    logic [16:0] got [8];
    logic [16:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 32'(ov), 32'd0);
    check("reset_in_ready", 32'(in_rdy), 32'h7);
    check("reset_result", 32'(res[1]), 32'd0);

    // Directed vectors with hand-computed results.
    run_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0, 1'b0);
    run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b0);
    run_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 1'b0);
    run_one("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0, 1'b0);
    run_one("sub_equal",  16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 17'h10000, 1'b0, 1'b1);

    // Back-to-back stream with a three-cycle output stall.
    bi = 0;
    ng = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 6 && c <= 8);
      in_valid  = (bi < 8);
      a = 16'(bi); b = 16'(bi); cin = 1'b0; op = 1'b0;
      @(negedge clk);
      if (c == 6) held = res[1];
      if (c >= 6 && c <= 8) begin
        check("stall_out_valid", 32'(ov[1]), 32'd1);
        check("stall_in_ready", 32'(in_rdy[1]), 32'd0);
      end
      if (c == 7 || c == 8) check("stall_hold", 32'(res[1]), 32'(held));
      if (ov[1] && out_ready) begin
        if (ng < 8) got[ng] = res[1];
        ng++;
      end
      if (in_valid && in_rdy[1]) bi++;
    end
    check("stream_count", 32'(ng), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("stream_beat%0d", i), 32'(got[i]), 32'(2 * i));

    // Reset with three beats in flight.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1;
      a = 16'(100 + c); b = 16'(7 * c); cin = 1'b0; op = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(ov[1]), 32'd0);
    check("flush_in_ready", 32'(in_rdy[1]), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("flush_no_stale", 32'(ov), 32'd0);
    end

    // Random valid/ready traffic with corner-biased operands.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 7))
        0:       a = 16'hFFFF;
        1:       a = 16'h8000;
        2:       a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 16'hFFFF;
        1:       b = 16'h0000;
        2:       b = 16'h8000;
        default: b = 16'($urandom);
      endcase
      cin = 1'($urandom);
      op  = 1'($urandom);
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("drained_dut%0d", d), 32'(qsize(d)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
